elixirchip_es1_spu_sll_arbiter: RTL and testbench



---
 rtl/elixirchip_es1_spu_arb_pkg.sv | 54 +++++
 rtl/elixirchip_es1_spu_op_sll.sv | 68 ++++++
 rtl/elixirchip_es1_spu_sll_arbiter.sv | 109 ++++++++++
 tb/tb_elixirchip_es1_spu_sll_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_arb_pkg.sv
// Shared types and helpers for the SPU round-robin operator arbiters.
package elixirchip_es1_spu_arb_pkg;

  localparam int unsigned MAX_REQ     = 16;
  localparam int unsigned MAX_ID_BITS = 4;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  // Tag width for n requesters; a single requester still needs one bit.
  function automatic int unsigned calc_id_bits(input int unsigned n);
    int unsigned bits;
    bits = (n <= 2) ? 1 : 32'($clog2(n));
    return bits;
  endfunction

  // One-hot grant: first valid requester at or after ptr, wrapping at num.
  function automatic req_vec_t rr_pick(input req_vec_t valid,
                                       input int unsigned ptr,
                                       input int unsigned num);
    req_vec_t    grant;
    logic        found;
    int unsigned sum;
    logic [MAX_ID_BITS-1:0] idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < num) begin
        sum = ptr + i;
        if (sum >= num) begin
          sum = sum - num;
        end
        idx = MAX_ID_BITS'(sum);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

  // Index of the set bit; zero when nothing is set.
  function automatic int unsigned onehot2idx(input req_vec_t onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_sll.sv
// Logical left shifter with a configurable register pipeline (LATENCY=0 is purely combinational).
module elixirchip_es1_spu_op_sll #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned SHIFT_BITS = 3,
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic [SHIFT_BITS-1:0] s_shift,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [DATA_BITS-1:0]  m_data
);

  // Idle stages are zeroed in debug/simulation builds so waveforms stay readable.
  localparam bit CLEAR_IDLE = (DEBUG == "true") || (SIMULATION == "true");

  logic [DATA_BITS-1:0] shifted;

  if (DEVICE == "RTL") begin : g_shift_op
    assign shifted = s_data << s_shift;
  end else begin : g_shift_barrel
    // Explicit log-depth mux chain for targets that map shifts poorly.
    logic [DATA_BITS-1:0] acc;
    always_comb begin
      acc = s_data;
      for (int b = 0; b < int'(SHIFT_BITS); b++) begin
        if (s_shift[b]) begin
          acc = acc << (1 << b);
        end
      end
    end
    assign shifted = acc;
  end

  if (LATENCY == 0) begin : g_comb
    assign m_data = (s_clear || (CLEAR_IDLE && !s_valid)) ? '0 : shifted;
  end else begin : g_pipe
    logic [LATENCY-1:0][DATA_BITS-1:0] stage;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage <= '0;
      end else if (cke) begin
        if (s_clear) begin
          stage <= '0;
        end else begin
          if (s_valid) begin
            stage[0] <= shifted;
          end else if (CLEAR_IDLE) begin
            stage[0] <= '0;
          end
          for (int k = 1; k < int'(LATENCY); k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end
    end

    assign m_data = stage[LATENCY-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_sll_arbiter.sv
// Round-robin arbiter sharing one SLL shifter among NUM_REQ requesters; results carry the requester tag.
module elixirchip_es1_spu_sll_arbiter
  import elixirchip_es1_spu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned SHIFT_BITS = $clog2(DATA_BITS),
  parameter int unsigned ID_BITS    = calc_id_bits(NUM_REQ),
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input  logic                            reset,
  input  logic                            clk,
  input  logic                            cke,
  input  logic [NUM_REQ*DATA_BITS-1:0]    s_data,
  input  logic [NUM_REQ*SHIFT_BITS-1:0]   s_shift,
  input  logic [NUM_REQ-1:0]              s_valid,
  output logic [NUM_REQ-1:0]              s_ready,
  output logic [DATA_BITS-1:0]            m_data,
  output logic [ID_BITS-1:0]              m_id,
  output logic                            m_valid,
  output logic                            m_busy
);

  logic [ID_BITS-1:0]    rr_ptr;
  req_vec_t              pick;
  logic [NUM_REQ-1:0]    grant;
  logic                  handshake;
  logic [ID_BITS-1:0]    grant_id;
  logic [ID_BITS-1:0]    next_ptr;
  logic [DATA_BITS-1:0]  issue_data;
  logic [SHIFT_BITS-1:0] issue_shift;

  // Combinational arbitration and issue mux; grants are suppressed while stalled or in reset.
  always_comb begin
    pick        = rr_pick(MAX_REQ'(s_valid), 32'(rr_ptr), NUM_REQ);
    grant       = (cke && !reset) ? pick[NUM_REQ-1:0] : '0;
    handshake   = |grant;
    grant_id    = ID_BITS'(onehot2idx(pick));
    next_ptr    = ((32'(grant_id) + 32'd1) >= NUM_REQ) ? '0 : grant_id + 1'b1;
    issue_data  = '0;
    issue_shift = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        issue_data  = s_data[i*DATA_BITS +: DATA_BITS];
        issue_shift = s_shift[i*SHIFT_BITS +: SHIFT_BITS];
      end
    end
  end

  assign s_ready = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= next_ptr;
    end
  end

  elixirchip_es1_spu_op_sll #(
    .LATENCY    (LATENCY),
    .DATA_BITS  (DATA_BITS),
    .SHIFT_BITS (SHIFT_BITS),
    .DEVICE     (DEVICE),
    .SIMULATION (SIMULATION),
    .DEBUG      (DEBUG)
  ) u_sll (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_data  (issue_data),
    .s_shift (issue_shift),
    .s_clear (1'b0),
    .s_valid (handshake),
    .m_data  (m_data)
  );

  if (LATENCY == 0) begin : g_tag_comb
    assign m_valid = handshake;
    assign m_id    = grant_id;
    assign m_busy  = 1'b0;
  end else begin : g_tag_pipe
    // Tag stages mirror the shifter stages so m_id lines up with m_data.
    logic [LATENCY-1:0]              tag_valid;
    logic [LATENCY-1:0][ID_BITS-1:0] tag_id;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag_valid <= '0;
        tag_id    <= '0;
      end else if (cke) begin
        tag_valid[0] <= handshake;
        tag_id[0]    <= grant_id;
        for (int k = 1; k < int'(LATENCY); k++) begin
          tag_valid[k] <= tag_valid[k-1];
          tag_id[k]    <= tag_id[k-1];
        end
      end
    end

    assign m_valid = tag_valid[LATENCY-1];
    assign m_id    = tag_id[LATENCY-1];
    assign m_busy  = |tag_valid;
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_sll_arbiter.sv
// Directed bench: table of per-cycle vectors plus hand sequences for stall, async reset and LATENCY=0.
module tb_elixirchip_es1_spu_sll_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [31:0] s_data;
  logic [11:0] s_shift;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_id;
  logic        m_valid;
  logic        m_busy;

  logic        z_cke;
  logic [31:0] z_data;
  logic [11:0] z_shift;
  logic [3:0]  z_valid;
  logic [3:0]  z_ready;
  logic [7:0]  z_mdata;
  logic [1:0]  z_mid;
  logic        z_mvalid;
  logic        z_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_sll_arbiter #(
    .NUM_REQ(4), .LATENCY(2), .DATA_BITS(8)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_data(s_data), .s_shift(s_shift), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_id(m_id), .m_valid(m_valid), .m_busy(m_busy)
  );

  elixirchip_es1_spu_sll_arbiter #(
    .NUM_REQ(4), .LATENCY(0), .DATA_BITS(8)
  ) dut0 (
    .reset(reset), .clk(clk), .cke(z_cke),
    .s_data(z_data), .s_shift(z_shift), .s_valid(z_valid), .s_ready(z_ready),
    .m_data(z_mdata), .m_id(z_mid), .m_valid(z_mvalid), .m_busy(z_busy)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [11:0] shift;
    logic [3:0]  ready;
    logic        mv;
    logic [1:0]  mid;
    logic [7:0]  md;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D_ONES   = 32'h01010101;
  localparam logic [11:0] SH_IDX   = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [31:0] D_SINGLE = 32'h000F0000;
  localparam logic [11:0] SH_SGL   = {3'd0, 3'd3, 3'd0, 3'd0};
  localparam logic [31:0] D_FAIR   = 32'h81000300;
  localparam logic [11:0] SH_FAIR  = {3'd1, 3'd0, 3'd1, 3'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [31:0] d, input logic [11:0] sh,
                     input logic [3:0] rdy, input logic mv, input logic [1:0] mid,
                     input logic [7:0] md, input logic busy);
    vec_t r;
    r.valid = v; r.data = d; r.shift = sh; r.ready = rdy;
    r.mv = mv; r.mid = mid; r.md = md; r.busy = busy;
    vecs.push_back(r);
  endtask

  // Checks mid-cycle, then advances to 1 time unit past the next rising edge.
  task automatic step_check(input string tag, input logic [3:0] rdy, input logic mv,
                            input logic [1:0] mid, input logic [7:0] md, input logic busy);
    #1;
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(rdy));
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(mv));
    chk({tag, ".m_busy"},  32'(m_busy),  32'(busy));
    if (mv) begin
      chk({tag, ".m_id"},   32'(m_id),   32'(mid));
      chk({tag, ".m_data"}, 32'(m_data), 32'(md));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; s_data = '0; s_shift = '0; s_valid = '0;
    z_cke = 1'b1; z_data = '0; z_shift = '0; z_valid = '0;

    // reset state
    add(4'h0, '0, '0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    // full contention from rr_ptr=0
    add(4'hF, D_ONES, SH_IDX, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
    add(4'hF, D_ONES, SH_IDX, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1);
    add(4'hF, D_ONES, SH_IDX, 4'b0100, 1'b1, 2'd0, 8'h01, 1'b1);
    add(4'hF, D_ONES, SH_IDX, 4'b1000, 1'b1, 2'd1, 8'h02, 1'b1);
    add(4'hF, D_ONES, SH_IDX, 4'b0001, 1'b1, 2'd2, 8'h04, 1'b1);
    add(4'hF, D_ONES, SH_IDX, 4'b0010, 1'b1, 2'd3, 8'h08, 1'b1);
    add(4'hF, D_ONES, SH_IDX, 4'b0100, 1'b1, 2'd0, 8'h01, 1'b1);
    add(4'hF, D_ONES, SH_IDX, 4'b1000, 1'b1, 2'd1, 8'h02, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b1, 2'd2, 8'h04, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b1, 2'd3, 8'h08, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    // single request: req2 0x0F << 3
    add(4'b0100, D_SINGLE, SH_SGL, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0);
    add(4'h0, '0, '0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b1, 2'd2, 8'h78, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    // pointer fairness after req2: req3 before req1; 0x81<<1 truncates to 0x02
    add(4'b1010, D_FAIR, SH_FAIR, 4'b1000, 1'b0, 2'd0, 8'h00, 1'b0);
    add(4'b0010, D_FAIR, SH_FAIR, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b1, 2'd3, 8'h02, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b1, 2'd1, 8'h06, 1'b1);
    add(4'h0, '0, '0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset.m_id", 32'(m_id), 32'd0);

    foreach (vecs[i]) begin
      s_valid = vecs[i].valid;
      s_data  = vecs[i].data;
      s_shift = vecs[i].shift;
      step_check($sformatf("vec%0d", i), vecs[i].ready, vecs[i].mv,
                 vecs[i].mid, vecs[i].md, vecs[i].busy);
    end

    // cke stall with two results in flight (rr_ptr=2 here)
    s_data  = 32'h00110580;
    s_shift = {3'd0, 3'd2, 3'd1, 3'd0};
    s_valid = 4'b0110;
    step_check("stall.issue2", 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0);
    s_valid = 4'b0010;
    step_check("stall.issue1", 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1);
    s_valid = 4'b0001;
    cke = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_check($sformatf("stall.hold%0d", k), 4'h0, 1'b1, 2'd2, 8'h44, 1'b1);
    end
    cke = 1'b1;
    step_check("stall.out2", 4'b0001, 1'b1, 2'd2, 8'h44, 1'b1);
    s_valid = 4'h0;
    step_check("stall.out1", 4'h0, 1'b1, 2'd1, 8'h0A, 1'b1);
    step_check("stall.out0", 4'h0, 1'b1, 2'd0, 8'h80, 1'b1);
    step_check("stall.drain", 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);

    // async reset between edges with two results in flight (rr_ptr=1 here)
    s_valid = 4'b0011;
    step_check("areset.issue1", 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0);
    s_valid = 4'b0001;
    step_check("areset.issue0", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1);
    s_valid = 4'h0;
    #1;
    chk("areset.pre_valid", 32'(m_valid), 32'd1);
    chk("areset.pre_busy",  32'(m_busy),  32'd1);
    reset = 1'b1;
    s_valid = 4'hF;
    #1;
    chk("areset.m_valid", 32'(m_valid), 32'd0);
    chk("areset.m_busy",  32'(m_busy),  32'd0);
    chk("areset.s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("areset.first_grant", 32'(s_ready), 32'b0001);
    @(posedge clk);
    #1 s_valid = 4'h0;

    // LATENCY=0 instance: same-cycle result
    z_valid = 4'b0010;
    z_data  = 32'h0000FF00;
    z_shift = {3'd0, 3'd0, 3'd7, 3'd0};
    #1;
    chk("lat0.s_ready", 32'(z_ready),  32'b0010);
    chk("lat0.m_valid", 32'(z_mvalid), 32'd1);
    chk("lat0.m_id",    32'(z_mid),    32'd1);
    chk("lat0.m_data",  32'(z_mdata),  32'h80);
    chk("lat0.m_busy",  32'(z_busy),   32'd0);
    @(posedge clk);
    #1 z_valid = 4'h0;
    #1 chk("lat0.idle_valid", 32'(z_mvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
